mux_nto1_pipe: RTL and testbench
================================

MUX_NTO1_PIPE -- requirements
Module: mux_nto1_pipe

Interface
REQ-001 Parameter WIDTH, default 12, data width per channel in bits (1..64).
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter SELW, default 2, select width; SHALL equal ceil(log2(N)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-007 in_valid  input  N  per-channel data valid.
REQ-008 in_ready  output  N  per-channel accept; transfer on channel i when in_valid[i] and in_ready[i] are both 1 at a rising edge.
REQ-009 sel  input  SELW  channel select, used in direct mode.
REQ-010 mode  input  1  0 = direct select, 1 = round-robin (see REQ-030).
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds an untransferred word.
REQ-013 out_ready  input  1  downstream accept; transfer when out_valid and out_ready are both 1.
REQ-014 out_ch  output  SELW  index of the channel that supplied the current out_data.

Function
REQ-015 Block SHALL hold one output entry (out_data, out_ch, out_valid); it is not combinational: latency from input transfer to out_valid is exactly 1 cycle.
REQ-016 can_load = !out_valid || out_ready (entry empty or being drained in the same cycle).
REQ-017 Direct mode: granted channel g = sel; if sel >= N, no channel is granted.
REQ-018 in_ready[i] SHALL be 1 only when i == g, a grant exists, and can_load; all other bits 0. in_ready does not depend on in_valid[g].
REQ-019 On input transfer: out_data <= channel g data, out_ch <= g, out_valid <= 1.
REQ-020 Output transfer without input transfer in the same cycle: out_valid <= 0; out_data and out_ch hold their last values.
REQ-021 Simultaneous output and input transfer: the new word replaces the old one and out_valid stays 1, giving full throughput of 1 word/cycle.
REQ-022 out_valid=1 with out_ready=0: out_data, out_ch and out_valid SHALL stay stable, and all in_ready bits SHALL be 0.
REQ-023 Changing sel or mode while out_valid=1 SHALL NOT alter the held entry; it affects only the next grant.
REQ-024 Data of non-granted channels SHALL never reach out_data.

Reset
REQ-025 While reset_n=0 at a rising edge: out_valid <= 0, out_data <= 0, out_ch <= 0, rr_ptr <= 0.
REQ-026 During reset, in_ready SHALL be all 0, whatever the inputs.
REQ-027 A reset asserted while out_valid=1 SHALL discard the held word, and no transfer is counted in that cycle.
REQ-028 In the first cycle after reset_n returns to 1, normal operation applies (in_ready may assert).

Configuration
REQ-029 Macro MUX_RR_ARB_EN controls whether the round-robin arbiter is compiled in.
REQ-030 With MUX_RR_ARB_EN defined and mode=1: g = the first index i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., N-1, 0, ... (wrapping). If no in_valid bit is set, there is no grant.
REQ-031 With MUX_RR_ARB_EN defined: on each input transfer in mode 1, rr_ptr <= (g+1) mod N, so after N-1 the pointer wraps to 0. rr_ptr holds otherwise, including in mode 0.
REQ-032 Without MUX_RR_ARB_EN: mode is ignored, direct mode always applies, and no rr_ptr register exists.

Verification
REQ-033 Direct mode, N=4, WIDTH=12: sel=2, in_valid=4'b0100, ch2=12'hABC, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=12'hABC, out_ch=2.
REQ-034 Backpressure: out_valid=1, out_ready=0 for 3 cycles, ch1 valid with 12'h123 -> in_ready=0 and out_data stable for those 3 cycles; when out_ready=1, ch1 is accepted the same cycle and appears 1 cycle later.
REQ-035 Streaming: sel=0, in_valid[0] held 1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data is 1,2,3,4 on consecutive cycles with no bubbles.
REQ-036 Round-robin (MUX_RR_ARB_EN, mode=1): in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0; with in_valid=4'b1001 -> out_ch sequence 0,3,0,3.
REQ-037 Out-of-range select: N=3, sel=3, in_valid=3'b111 -> in_ready=0 and out_valid stays 0.
REQ-038 Reset mid-operation: out_valid=1, out_data=12'h5A5, reset_n=0 for 1 edge -> out_valid=0, out_data=0, out_ch=0, and the round-robin sequence restarts at channel 0.

Source files
------------

// File: rtl/mux_nto1_pipe.sv
// N-to-1 channel multiplexer with a single registered output entry and valid/ready handshakes.
// Optional round-robin arbiter is compiled in with `define MUX_RR_ARB_EN (mode=1 selects it).
module mux_nto1_pipe #(
    parameter int WIDTH = 12,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_ch
);

    logic              can_load;
    logic              direct_vld;
    logic              grant_vld;
    logic [SELW-1:0]   grant;
    logic [WIDTH-1:0]  grant_data;
    logic              in_xfer;

    assign can_load   = !out_valid || out_ready;
    assign direct_vld = int'(sel) < N;

`ifdef MUX_RR_ARB_EN
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] rr_lo;
    logic [SELW-1:0] rr_hi;
    logic            rr_any;
    logic            rr_hi_vld;

    // Lowest valid index at/above rr_ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        rr_lo     = '0;
        rr_hi     = '0;
        rr_any    = 1'b0;
        rr_hi_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                rr_any = 1'b1;
                rr_lo  = SELW'(i);
                if (i >= int'(rr_ptr)) begin
                    rr_hi_vld = 1'b1;
                    rr_hi     = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        grant     = sel;
        grant_vld = direct_vld;
        if (mode) begin
            grant     = rr_hi_vld ? rr_hi : rr_lo;
            grant_vld = rr_any;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (in_xfer && mode) begin
            if (int'(grant) == N - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant + 1'b1;
            end
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        grant     = sel;
        grant_vld = direct_vld;
    end
`endif

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = grant_vld && can_load && reset_n;
            end
        end
    end

    assign in_xfer = |(in_ready & in_valid);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: spec-level model compared every cycle plus literal directed checks.
// Round-robin checks run only when MUX_RR_ARB_EN is defined.
module tb_mux_nto1_pipe;
    localparam int W = 12;
    localparam int N = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [S-1:0]   sel;
    logic           mode;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [S-1:0]   out_ch;

    logic [3*W-1:0] in3_data;
    logic [2:0]     in3_valid;
    logic [2:0]     in3_ready;
    logic [1:0]     sel3;
    logic [W-1:0]   out3_data;
    logic           out3_valid;
    logic [1:0]     out3_ch;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_nto1_pipe #(.WIDTH(W), .N(N), .SELW(S)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    mux_nto1_pipe #(.WIDTH(W), .N(3), .SELW(2)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .in_data(in3_data), .in_valid(in3_valid),
        .in_ready(in3_ready), .sel(sel3), .mode(1'b0), .out_data(out3_data),
        .out_valid(out3_valid), .out_ready(1'b1), .out_ch(out3_ch)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setch(input int i, input logic [W-1:0] v);
        in_data[i*W +: W] = v;
    endtask

    // Reference model: one output slot plus rotating pointer.
    logic           chk_en = 1'b0;
    logic           m_valid, n_valid;
    logic [W-1:0]   m_data, n_data;
    int             m_ch, n_ch;
    int             m_ptr, n_ptr;

    always @(negedge clk) begin
        if (chk_en) begin
            int  g;
            bit  have;
            bit  rr;
            logic [N-1:0] exp_rdy;
            rr = 1'b0;
`ifdef MUX_RR_ARB_EN
            rr = (mode == 1'b1);
`endif
            have = 1'b0;
            g = 0;
            if (rr) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (!have && in_valid[idx]) begin
                        have = 1'b1;
                        g = idx;
                    end
                end
            end else begin
                g = int'(sel);
                have = (g < N);
            end
            exp_rdy = '0;
            if (reset_n && have && (!m_valid || out_ready)) exp_rdy[g] = 1'b1;

            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("out_data", 64'(out_data), 64'(m_data));
            chk("out_ch", 64'(out_ch), 64'(m_ch));
            chk("n3_in_ready", 64'(in3_ready), 64'd0);
            chk("n3_out_valid", 64'(out3_valid), 64'd0);

            n_valid = m_valid;
            n_data  = m_data;
            n_ch    = m_ch;
            n_ptr   = m_ptr;
            if (|(exp_rdy & in_valid)) begin
                n_valid = 1'b1;
                n_data  = in_data[g*W +: W];
                n_ch    = g;
                if (rr) n_ptr = (g + 1) % N;
            end else if (m_valid && out_ready) begin
                n_valid = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            chk_en  = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = 0;
        end else if (chk_en) begin
            m_valid = n_valid;
            m_data  = n_data;
            m_ch    = n_ch;
            m_ptr   = n_ptr;
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_data   = '0;
        in_valid  = 4'b0100;
        sel       = 2'd2;
        mode      = 1'b0;
        out_ready = 1'b1;
        in3_data  = {12'h333, 12'h222, 12'h111};
        in3_valid = 3'b111;
        sel3      = 2'd3;
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);

        // Direct select of channel 2
        setch(2, 12'hABC);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("direct_in_ready", 64'(in_ready), 64'h4);
        tick();
        in_valid = '0;
        @(negedge clk);
        chk("direct_out_valid", 64'(out_valid), 64'd1);
        chk("direct_out_data", 64'(out_data), 64'hABC);
        chk("direct_out_ch", 64'(out_ch), 64'd2);
        tick();

        // Backpressure, with sel wiggled while the entry is held
        sel = 2'd1;
        setch(1, 12'h777);
        in_valid = 4'b0010;
        tick();
        out_ready = 1'b0;
        setch(1, 12'h123);
        for (int c = 0; c < 3; c++) begin
            sel = (c == 1) ? 2'd3 : 2'd1;
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_data", 64'(out_data), 64'h777);
            chk("bp_out_ch", 64'(out_ch), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(in_ready), 64'h2);
        tick();
        in_valid = '0;
        @(negedge clk);
        chk("bp_out_data_new", 64'(out_data), 64'h123);
        tick();

        // Streaming on channel 0
        sel = 2'd0;
        in_valid = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            setch(0, 12'(k));
            tick();
            @(negedge clk);
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_data", 64'(out_data), 64'(k));
        end
        in_valid = '0;
        tick();

        // Mixed pattern table, model-checked
        for (int k = 0; k < 40; k++) begin
            in_valid  = 4'((k * 5 + k / 7) % 16);
            sel       = 2'(k % 4);
            out_ready = (k % 3) != 0;
            for (int i = 0; i < N; i++) setch(i, 12'(k * 37 + i * 101));
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        tick();
        tick();

`ifdef MUX_RR_ARB_EN
        begin
            int exp_a[5] = '{0, 1, 2, 3, 0};
            mode = 1'b1;
            in_valid = 4'b1111;
            for (int k = 0; k < 5; k++) begin
                tick();
                @(negedge clk);
                chk("rr_all_ch", 64'(out_ch), 64'(exp_a[k]));
            end
            in_valid = '0;
            mode = 1'b0;
            tick();
        end
`endif

        // Reset while a word is held
        sel = 2'd0;
        setch(0, 12'h5A5);
        in_valid = 4'b0001;
        tick();
        in_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("held_data", 64'(out_data), 64'h5A5);
        tick();
        reset_n = 1'b0;
        in_valid = 4'b1111;
        @(negedge clk);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_data", 64'(out_data), 64'd0);
        chk("rst_mid_ch", 64'(out_ch), 64'd0);
        reset_n = 1'b1;
        out_ready = 1'b1;
        in_valid = '0;

`ifdef MUX_RR_ARB_EN
        begin
            int exp_b[4] = '{0, 3, 0, 3};
            mode = 1'b1;
            in_valid = 4'b1001;
            for (int k = 0; k < 4; k++) begin
                tick();
                @(negedge clk);
                chk("rr_1001_ch", 64'(out_ch), 64'(exp_b[k]));
            end
            in_valid = '0;
            mode = 1'b0;
        end
`else
        mode = 1'b1;
        sel = 2'd3;
        in_valid = 4'b1001;
        setch(3, 12'h3C3);
        tick();
        @(negedge clk);
        chk("mode_ignored_ch", 64'(out_ch), 64'd3);
        in_valid = '0;
        mode = 1'b0;
`endif
        tick();
        tick();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
